irrigation_valve_sequencer: RTL and testbench
=============================================

# irrigation_valve_sequencer

Upstream control stage for the irrigation valve flip-flop: synchronises and debounces the soil-moisture and tank-level sensors, runs the watering state machine, and drives the `j`/`k` inputs of the `jk_flipflop` that holds the valve state. It reads that flip-flop's `q` back as feedback to detect a stuck valve. It enforces a maximum watering time and a minimum rest time between cycles.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised samples required to change a filtered sensor value (≥1).
- `MAX_ON_CYCLES`, 100: maximum cycles spent in WATER (1..2^CW-1).
- `MIN_OFF_CYCLES`, 20: cycles spent in REST after every close (1..2^CW-1).
- `CW`, 8: width of the on/off counters.
- `clk` in 1: single system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset; 0 = reset asserted.
- `enable` in 1: operator enable, already synchronous to `clk`.
- `soil_dry` in 1: raw moisture sensor, 1 = dry; asynchronous.
- `tank_low` in 1: raw tank-level sensor, 1 = water low; asynchronous.
- `valve_q` in 1: `q` fed back from the valve `jk_flipflop`.
- `valve_j` out 1: drives `j` of the valve flip-flop.
- `valve_k` out 1: drives `k` of the valve flip-flop.
- `watering` out 1: high while state is WATER.
- `alarm` out 1: high while state is FAULT.
- `timeout_flag` out 1: sticky; set when WATER exits on the time limit; cleared on the next OPEN or on reset.

## Operation
- Each raw sensor passes through a 2-FF synchroniser, then a debouncer. The filtered value (`dry_f`, `low_f`) takes the synchronised value once it has differed from the filtered value for `DEBOUNCE_CYCLES` consecutive cycles. Any mismatch-free cycle clears the debounce counter.
- FSM states: IDLE, OPEN, WATER, CLOSE, REST, FAULT.
- IDLE: go to OPEN when `enable & dry_f & ~low_f`; otherwise stay.
- OPEN: exactly one cycle; `valve_j`=1, `valve_k`=0; clear the on-counter and `timeout_flag`; go to WATER.
- WATER: the on-counter increments every cycle. Transition priority:
  - `valve_q`=0 → FAULT.
  - Else `~enable | low_f | ~dry_f` → CLOSE.
  - Else on-counter = MAX_ON_CYCLES-1 → CLOSE and set `timeout_flag`.
- CLOSE: exactly one cycle; `valve_k`=1; clear the off-counter; go to REST.
- REST: the off-counter increments every cycle.
  - `valve_q`=1 → FAULT.
  - Else off-counter = MIN_OFF_CYCLES-1 → IDLE.
- FAULT: `valve_k` held at 1 and `alarm`=1. Exit to IDLE only when `enable`=0.
- Output decode is Moore, from the state register only:
  - `valve_j` = (state==OPEN).
  - `valve_k` = (state==CLOSE | state==FAULT).
  - `valve_j` & `valve_k` is never 1, so the flip-flop toggle code is never issued.
- Counters saturate, never wrap. MAX/MIN compares use CW-bit unsigned arithmetic.

## Timing
- Reset values:
  - State is IDLE.
  - All outputs are 0.
  - Synchronisers, filtered sensors and counters are 0.
- Reset mid-operation returns to IDLE immediately, with `valve_j`=`valve_k`=0. The valve flip-flop is reset by the same system reset.
- Sensor latency: a raw change stable from edge 0 appears on the filtered signal at edge 2+DEBOUNCE_CYCLES.
- Open latency: the FSM enters OPEN one edge after the start condition. The flip-flop samples `j`=1 at the edge that moves the FSM into WATER, so `valve_q`=1 from the first WATER cycle.
- Close latency: CLOSE → REST edge also sets `valve_q`=0.
- Watering duration: WATER lasts at most MAX_ON_CYCLES cycles.
- Rest duration: REST always lasts exactly MIN_OFF_CYCLES cycles unless a fault occurs.
- Simultaneous events in WATER: fault wins over sensor/enable exit, which wins over timeout. `timeout_flag` is set only when no other exit applies.
- Start condition dropping during OPEN has no effect; WATER exits on its next cycle.

## Structure
- Shared package `irrigation_pkg`: state enum with fixed 3-bit encodings IDLE=0, OPEN=1, WATER=2, CLOSE=3, REST=4, FAULT=5; default parameter constants.
- Sub-module `input_debouncer` (synchroniser plus debounce counter; parameter DEBOUNCE_CYCLES), instantiated twice.
- The bench instantiates the sequencer together with `jk_flipflop`, with `valve_q` tied to `q`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, MAX_ON_CYCLES=10, MIN_OFF_CYCLES=5.
- Reset, then `enable`=1, `soil_dry`=1, `tank_low`=0 → `valve_j` pulses for 1 cycle; `valve_q`=1 and `watering`=1 starting 8 edges after `soil_dry` rises.
- `soil_dry` held at 1 through WATER → exactly 10 WATER cycles, then `valve_k` pulses once, `timeout_flag`=1, REST for 5 cycles, then IDLE and immediate restart.
- `soil_dry` glitches to 0 for 3 cycles during WATER → no exit. Held at 0 for 4 cycles → CLOSE, `timeout_flag`=0.
- `tank_low` rises in WATER → CLOSE. No new OPEN while `low_f`=1, even with `soil_dry`=1.
- Force `valve_q`=0 in WATER → FAULT, `alarm`=1, `valve_k`=1. Drop `enable` → IDLE, `alarm`=0.
- Assert `reset` (0) in WATER and REST → all outputs are 0 at once. On release, the FSM restarts from IDLE.
- Assertion over every cycle: never `valve_j`=`valve_k`=1.

Source files
------------

// File: rtl/irrigation_pkg.sv
// Shared definitions for the irrigation valve sequencer: the watering state
// encoding, default timing constants and the valve drive decode helpers.
package irrigation_pkg;

    // Fixed encodings so state values stay stable across revisions and in
    // waveforms viewed by other teams.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        OPEN  = 3'd1,
        WATER = 3'd2,
        CLOSE = 3'd3,
        REST  = 3'd4,
        FAULT = 3'd5
    } valve_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_MAX_ON_CYCLES   = 100;
    localparam int DEF_MIN_OFF_CYCLES  = 20;
    localparam int DEF_CW              = 8;

    // The valve flip-flop is set only from OPEN.
    function automatic logic valve_j_level(input valve_state_t s);
        return (s == OPEN);
    endfunction

    // The valve flip-flop is cleared from CLOSE and held cleared in FAULT.
    // OPEN never overlaps these, so j and k are never high together.
    function automatic logic valve_k_level(input valve_state_t s);
        return (s == CLOSE) || (s == FAULT);
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a consecutive-sample debounce filter for
// one asynchronous sensor line.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filtered
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // The filter flips on the edge that sees the last required mismatch.
    localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          filt_r;
    logic [DW-1:0] cnt_r;
    logic          filt_next_s;
    logic [DW-1:0] cnt_next_s;

    // Bring the raw sensor into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Count consecutive disagreements; any agreeing cycle restarts the count.
    always_comb begin
        filt_next_s = filt_r;
        cnt_next_s  = {DW{1'b0}};
        if (sync2_r != filt_r) begin
            if (cnt_r >= CNT_LAST) begin
                filt_next_s = sync2_r;
                cnt_next_s  = {DW{1'b0}};
            end else begin
                filt_next_s = filt_r;
                cnt_next_s  = cnt_r + DW'(1);
            end
        end else begin
            filt_next_s = filt_r;
            cnt_next_s  = {DW{1'b0}};
        end
    end

    // Hold the filtered value and the debounce count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_r <= 1'b0;
            cnt_r  <= {DW{1'b0}};
        end else begin
            filt_r <= filt_next_s;
            cnt_r  <= cnt_next_s;
        end
    end

    assign filtered = filt_r;

endmodule

// File: rtl/irrigation_valve_sequencer_chk.sv
// Protocol checker for the valve sequencer outputs.
module irrigation_valve_sequencer_chk (
    input logic clk,
    input logic reset,
    input logic valve_j,
    input logic valve_k,
    input logic watering,
    input logic alarm
);

    // The toggle code would flip the valve blindly, so it must never appear.
    no_toggle_code: assert property (@(posedge clk) disable iff (!reset)
        !(valve_j && valve_k));

    // Watering and fault are distinct states.
    no_water_in_fault: assert property (@(posedge clk) disable iff (!reset)
        !(watering && alarm));

endmodule

// File: rtl/jk_flipflop.sv
// Valve state holder: classic JK flip-flop with asynchronous active-low reset.
module jk_flipflop (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_r;

    // 00 hold, 01 clear, 10 set, 11 toggle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   q_r <= q_r;
                2'b01:   q_r <= 1'b0;
                2'b10:   q_r <= 1'b1;
                2'b11:   q_r <= ~q_r;
                default: q_r <= q_r;
            endcase
        end
    end

    assign q = q_r;

endmodule

// File: rtl/irrigation_valve_sequencer.sv
// Watering sequencer: filters the soil and tank sensors, runs the
// open/water/close/rest cycle with on-time and rest-time limits, drives the
// valve JK flip-flop and watches its q for a stuck valve.
module irrigation_valve_sequencer
    import irrigation_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int MAX_ON_CYCLES   = DEF_MAX_ON_CYCLES,
    parameter int MIN_OFF_CYCLES  = DEF_MIN_OFF_CYCLES,
    parameter int CW              = DEF_CW
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic soil_dry,
    input  logic tank_low,
    input  logic valve_q,
    output logic valve_j,
    output logic valve_k,
    output logic watering,
    output logic alarm,
    output logic timeout_flag
);

    localparam logic [CW-1:0] ON_LAST  = CW'(MAX_ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(MIN_OFF_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

    valve_state_t  state_r;
    valve_state_t  next_state_s;
    logic [CW-1:0] on_cnt_r;
    logic [CW-1:0] off_cnt_r;
    logic          timeout_r;
    logic          valve_j_r;
    logic          valve_k_r;
    logic          watering_r;
    logic          alarm_r;

    logic dry_f_s;
    logic low_f_s;
    logic start_s;
    logic stop_s;
    logic on_last_s;
    logic off_last_s;
    logic timeout_hit_s;
    logic valve_j_next_s;
    logic valve_k_next_s;
    logic watering_next_s;
    logic alarm_next_s;

    input_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dry_debounce (
        .clk      (clk),
        .reset    (reset),
        .raw      (soil_dry),
        .filtered (dry_f_s)
    );

    input_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_low_debounce (
        .clk      (clk),
        .reset    (reset),
        .raw      (tank_low),
        .filtered (low_f_s)
    );

    assign start_s    = enable & dry_f_s & ~low_f_s;
    assign stop_s     = ~enable | low_f_s | ~dry_f_s;
    assign on_last_s  = (on_cnt_r == ON_LAST);
    assign off_last_s = (off_cnt_r == OFF_LAST);
    // The time limit only counts as the exit reason when nothing else fired.
    assign timeout_hit_s = (state_r == WATER) & valve_q & ~stop_s & on_last_s;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; in WATER a stuck valve beats the sensor/enable exit,
    // which beats the time limit.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    next_state_s = OPEN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            OPEN: begin
                next_state_s = WATER;
            end
            WATER: begin
                if (!valve_q) begin
                    next_state_s = FAULT;
                end else if (stop_s) begin
                    next_state_s = CLOSE;
                end else if (on_last_s) begin
                    next_state_s = CLOSE;
                end else begin
                    next_state_s = WATER;
                end
            end
            CLOSE: begin
                next_state_s = REST;
            end
            REST: begin
                if (valve_q) begin
                    next_state_s = FAULT;
                end else if (off_last_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = REST;
                end
            end
            FAULT: begin
                if (!enable) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = FAULT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Output decode from the state being entered, so the registered outputs
    // line up exactly with the state register.
    always_comb begin
        valve_j_next_s  = valve_j_level(next_state_s);
        valve_k_next_s  = valve_k_level(next_state_s);
        watering_next_s = (next_state_s == WATER);
        alarm_next_s    = (next_state_s == FAULT);
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valve_j_r  <= 1'b0;
            valve_k_r  <= 1'b0;
            watering_r <= 1'b0;
            alarm_r    <= 1'b0;
        end else begin
            valve_j_r  <= valve_j_next_s;
            valve_k_r  <= valve_k_next_s;
            watering_r <= watering_next_s;
            alarm_r    <= alarm_next_s;
        end
    end

    // Watering time counter: cleared in OPEN, saturating count in WATER.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            on_cnt_r <= {CW{1'b0}};
        end else if (state_r == OPEN) begin
            on_cnt_r <= {CW{1'b0}};
        end else if ((state_r == WATER) && (on_cnt_r != CNT_SAT)) begin
            on_cnt_r <= on_cnt_r + CW'(1);
        end else begin
            on_cnt_r <= on_cnt_r;
        end
    end

    // Rest time counter: cleared in CLOSE, saturating count in REST.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            off_cnt_r <= {CW{1'b0}};
        end else if (state_r == CLOSE) begin
            off_cnt_r <= {CW{1'b0}};
        end else if ((state_r == REST) && (off_cnt_r != CNT_SAT)) begin
            off_cnt_r <= off_cnt_r + CW'(1);
        end else begin
            off_cnt_r <= off_cnt_r;
        end
    end

    // Sticky timeout indication, cleared when the next cycle opens the valve.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_r <= 1'b0;
        end else if (state_r == OPEN) begin
            timeout_r <= 1'b0;
        end else if (timeout_hit_s) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign valve_j      = valve_j_r;
    assign valve_k      = valve_k_r;
    assign watering     = watering_r;
    assign alarm        = alarm_r;
    assign timeout_flag = timeout_r;

endmodule

// File: tb/tb_irrigation_valve_sequencer.sv
// Scoreboard bench for the irrigation valve sequencer driving a JK valve
// flip-flop. Expected output snapshots {valve_q, valve_j, valve_k, watering,
// alarm, timeout_flag} are queued with the cycle they are due in when the
// stimulus is applied, and compared when that cycle's outputs appear.
module tb_irrigation_valve_sequencer;

    localparam int DEB    = 4;
    localparam int MAXON  = 10;
    localparam int MINOFF = 5;
    localparam int CWID   = 8;

    logic clk      = 1'b0;
    logic reset    = 1'b0;
    logic enable   = 1'b0;
    logic soil_dry = 1'b0;
    logic tank_low = 1'b0;
    logic force_q0 = 1'b0;
    logic q_ff;
    logic valve_q;
    logic valve_j;
    logic valve_k;
    logic watering;
    logic alarm;
    logic timeout_flag;
    logic [5:0] obs_s;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int base     = 0;
    int jk_viol  = 0;

    typedef struct {
        int         due;
        logic [5:0] exp;
        string      tag;
    } exp_t;

    exp_t sb_q[$];

    assign valve_q = force_q0 ? 1'b0 : q_ff;
    assign obs_s   = {valve_q, valve_j, valve_k, watering, alarm, timeout_flag};

    always #5 clk = ~clk;

    irrigation_valve_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .MAX_ON_CYCLES   (MAXON),
        .MIN_OFF_CYCLES  (MINOFF),
        .CW              (CWID)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .soil_dry     (soil_dry),
        .tank_low     (tank_low),
        .valve_q      (valve_q),
        .valve_j      (valve_j),
        .valve_k      (valve_k),
        .watering     (watering),
        .alarm        (alarm),
        .timeout_flag (timeout_flag)
    );

    jk_flipflop u_valve (
        .clk   (clk),
        .reset (reset),
        .j     (valve_j),
        .k     (valve_k),
        .q     (q_ff)
    );

    irrigation_valve_sequencer_chk u_chk (
        .clk      (clk),
        .reset    (reset),
        .valve_j  (valve_j),
        .valve_k  (valve_k),
        .watering (watering),
        .alarm    (alarm)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%0h want 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push_exp(input int rel, input logic [5:0] e, input string tag);
        exp_t item;
        item.due = base + rel;
        item.exp = e;
        item.tag = tag;
        sb_q.push_back(item);
    endtask

    task automatic go_to(input int rel);
        while (cyc < base + rel) @(negedge clk);
    endtask

    // Cycle count = number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Compare every queued snapshot that is due on this cycle.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due == cyc) begin
                check_val(sb_q[i].tag, {26'd0, obs_s}, {26'd0, sb_q[i].exp});
                sb_q.delete(i);
            end
        end
        if (reset && valve_j && valve_k) jk_viol <= jk_viol + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_val("reset_outputs", {26'd0, obs_s}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        base = cyc;

        // Start condition: opens 7 edges later, waters from edge 8, times out.
        enable = 1'b1; soil_dry = 1'b1; tank_low = 1'b0;
        push_exp(6,  6'b000000, "idle_debounce");
        push_exp(7,  6'b010000, "open_pulse");
        push_exp(8,  6'b100100, "water_first");
        push_exp(17, 6'b100100, "water_tenth");
        push_exp(18, 6'b101001, "close_timeout");
        push_exp(19, 6'b000001, "rest_first");
        push_exp(23, 6'b000001, "rest_fifth");
        push_exp(24, 6'b000001, "idle_after_rest");
        push_exp(25, 6'b010001, "reopen_flag_held");
        push_exp(26, 6'b100100, "water2_flag_clear");

        // 3-cycle dry glitch: filtered value must not change.
        go_to(27);
        soil_dry = 1'b0;
        push_exp(34, 6'b100100, "glitch_no_exit");
        push_exp(35, 6'b100100, "glitch_water_last");
        push_exp(36, 6'b101001, "close_timeout2");
        push_exp(41, 6'b000001, "rest2_last");
        push_exp(43, 6'b010001, "open3");
        push_exp(44, 6'b100100, "water3");
        go_to(30);
        soil_dry = 1'b1;

        // 4-cycle wet period: sensor exit, no timeout flag.
        go_to(44);
        soil_dry = 1'b0;
        push_exp(50, 6'b100100, "wet_water_still");
        push_exp(51, 6'b101000, "close_wet");
        push_exp(52, 6'b000000, "rest_wet");
        go_to(48);
        soil_dry = 1'b1;
        push_exp(58, 6'b010000, "open4");
        push_exp(59, 6'b100100, "water4");

        // Tank low in WATER closes; no restart while it stays low.
        go_to(59);
        tank_low = 1'b1;
        push_exp(65, 6'b100100, "low_water_still");
        push_exp(66, 6'b101000, "close_low");
        push_exp(67, 6'b000000, "rest_low");
        push_exp(72, 6'b000000, "idle_low");
        push_exp(80, 6'b000000, "no_open_low");
        go_to(80);
        tank_low = 1'b0;
        push_exp(87, 6'b010000, "open5");
        push_exp(88, 6'b100100, "water5");

        // Stuck valve in WATER.
        go_to(89);
        force_q0 = 1'b1;
        push_exp(90, 6'b001010, "fault_entry");
        push_exp(95, 6'b001010, "fault_hold");
        go_to(95);
        enable = 1'b0; force_q0 = 1'b0;
        push_exp(96, 6'b000000, "fault_exit");
        push_exp(98, 6'b000000, "idle_disabled");

        // Reset in WATER.
        go_to(98);
        enable = 1'b1;
        push_exp(99,  6'b010000, "open6");
        push_exp(100, 6'b100100, "water6");
        push_exp(102, 6'b100100, "water6_pre_reset");
        go_to(102);
        #2 reset = 1'b0;
        #1 check_val("reset_in_water", {26'd0, obs_s}, 32'd0);
        go_to(104);
        reset = 1'b1;
        push_exp(110, 6'b000000, "post_reset_idle");
        push_exp(111, 6'b010000, "post_reset_open");
        push_exp(112, 6'b100100, "post_reset_water");
        push_exp(122, 6'b101001, "post_reset_timeout");
        push_exp(123, 6'b000001, "rest7");

        // Reset in REST.
        go_to(124);
        #2 reset = 1'b0;
        #1 check_val("reset_in_rest", {26'd0, obs_s}, 32'd0);
        go_to(126);
        reset = 1'b1;
        push_exp(130, 6'b000000, "rest_reset_idle");
        push_exp(133, 6'b010000, "rest_reset_open");
        push_exp(134, 6'b100100, "rest_reset_water");

        go_to(136);
        check_val("scoreboard_drained", sb_q.size(), 32'd0);
        check_val("jk_never_both", jk_viol, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
